// File: rtl/writeback_queue_if.sv
// rtl/writeback_queue_if.sv - writeback queue enqueue, register-file write and forwarding signals
// slave is the queue itself; master is whoever feeds requests and observes writes.
interface writeback_queue_if;
    logic        in_valid;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        in_ready;
    logic        wb_hold;
    logic        regWrite;
    logic [4:0]  regWaddr;
    logic [31:0] data;
    logic [4:0]  fwd1addr;
    logic [4:0]  fwd2addr;
    logic        fwd1hit;
    logic        fwd2hit;
    logic [31:0] fwd1data;
    logic [31:0] fwd2data;
    logic        empty;

    modport slave (
        input  in_valid, in_addr, in_data, wb_hold, fwd1addr, fwd2addr,
        output in_ready, regWrite, regWaddr, data, fwd1hit, fwd2hit, fwd1data, fwd2data, empty
    );

    modport master (
        output in_valid, in_addr, in_data, wb_hold, fwd1addr, fwd2addr,
        input  in_ready, regWrite, regWaddr, data, fwd1hit, fwd2hit, fwd1data, fwd2data, empty
    );
endinterface

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - circular writeback FIFO draining into a register file write port
// Forwarding lookups are built only when WBQ_FORWARD_EN is defined; otherwise hits/data read 0.
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    writeback_queue_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [4:0]    addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];

    logic ready_w, empty_w, write_w, push, pop;

    always_comb begin
        ready_w  = count_q < CW'(DEPTH);
        empty_w  = (count_q == '0);
        write_w  = !empty_w && !bus.wb_hold;
        // Register 0 requests complete the handshake but never occupy a slot.
        push     = bus.in_valid && ready_w && (bus.in_addr != 5'd0);
        pop      = write_w;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d  = count_q;
        if (push && !pop) count_d = count_q + CW'(1);
        if (pop && !push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= bus.in_addr;
            data_q[wr_ptr_q] <= bus.in_data;
        end
    end

    assign bus.in_ready = ready_w;
    assign bus.empty    = empty_w;
    assign bus.regWrite = write_w;
    assign bus.regWaddr = addr_q[rd_ptr_q];
    assign bus.data     = data_q[rd_ptr_q];

`ifdef WBQ_FORWARD_EN
    logic [PW-1:0] idx;

    // Scan oldest to youngest so the last match wins.
    always_comb begin
        bus.fwd1hit  = 1'b0;
        bus.fwd2hit  = 1'b0;
        bus.fwd1data = '0;
        bus.fwd2data = '0;
        idx          = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (bus.fwd1addr != 5'd0 && addr_q[idx] == bus.fwd1addr) begin
                    bus.fwd1hit  = 1'b1;
                    bus.fwd1data = data_q[idx];
                end
                if (bus.fwd2addr != 5'd0 && addr_q[idx] == bus.fwd2addr) begin
                    bus.fwd2hit  = 1'b1;
                    bus.fwd2data = data_q[idx];
                end
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd   = ^{bus.fwd1addr, bus.fwd2addr};
    assign bus.fwd1hit  = 1'b0;
    assign bus.fwd2hit  = 1'b0;
    assign bus.fwd1data = '0;
    assign bus.fwd2data = '0;
`endif
endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - directed bench with queue-based reference model for writeback_queue
module tb_writeback_queue;
    localparam int DEPTH = 4;
`ifdef WBQ_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] val;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    writeback_queue_if bus();

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    entry_t model_q[$];
    entry_t wlog[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [32:0] model_fwd(input logic [4:0] a);
        if (!FWD || a == 5'd0) return '0;
        for (int i = model_q.size() - 1; i >= 0; i--)
            if (model_q[i].addr == a) return {1'b1, model_q[i].val};
        return '0;
    endfunction

    // Reference: pop happens when anything is queued and hold is low; push when room and addr != 0.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_q.delete();
        end else begin
            automatic bit do_pop  = (model_q.size() > 0) && !bus.wb_hold;
            automatic bit do_push = bus.in_valid && (model_q.size() < DEPTH) && (bus.in_addr != 5'd0);
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back('{addr: bus.in_addr, val: bus.in_data});
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            automatic bit       exp_we = (model_q.size() > 0) && !bus.wb_hold;
            automatic logic [32:0] f1 = model_fwd(bus.fwd1addr);
            automatic logic [32:0] f2 = model_fwd(bus.fwd2addr);
            chk("empty",    32'(bus.empty),    32'(model_q.size() == 0));
            chk("in_ready", 32'(bus.in_ready), 32'(model_q.size() < DEPTH));
            chk("regWrite", 32'(bus.regWrite), 32'(exp_we));
            if (exp_we) begin
                chk("regWaddr", 32'(bus.regWaddr), 32'(model_q[0].addr));
                chk("data",     bus.data,          model_q[0].val);
            end
            chk("fwd1hit",  32'(bus.fwd1hit), 32'(f1[32]));
            chk("fwd1data", bus.fwd1data,     f1[31:0]);
            chk("fwd2hit",  32'(bus.fwd2hit), 32'(f2[32]));
            chk("fwd2data", bus.fwd2data,     f2[31:0]);
            if (bus.regWrite) wlog.push_back('{addr: bus.regWaddr, val: bus.data});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [4:0] a, input logic [31:0] d);
        bus.in_valid = 1'b1;
        bus.in_addr  = a;
        bus.in_data  = d;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        bus.wb_hold = 1'b0;
        n = 0;
        while (!bus.empty && n < 20) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(bus.empty), 32'd1);
    endtask

    task automatic chk_log(input string name, input logic [4:0] first, input int n);
        chk({name, "_len"}, 32'(wlog.size()), 32'(n));
        for (int i = 0; i < n && i < wlog.size(); i++)
            chk({name, "_addr"}, 32'(wlog[i].addr), 32'(first + 5'(i)));
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_addr  = '0;
        bus.in_data  = '0;
        bus.wb_hold  = 1'b0;
        bus.fwd1addr = '0;
        bus.fwd2addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty",    32'(bus.empty),    32'd1);
        chk("rst_ready",    32'(bus.in_ready), 32'd1);
        chk("rst_regWrite", 32'(bus.regWrite), 32'd0);
        rst = 1'b0;
        step();

        // Single write: visible for exactly one cycle after the enqueue edge.
        wlog.delete();
        enq(5'd8, 32'h0000_000A);
        chk("s1_we",   32'(bus.regWrite), 32'd1);
        chk("s1_addr", 32'(bus.regWaddr), 32'd8);
        chk("s1_data", bus.data,          32'h0000_000A);
        step();
        chk("s1_we_off", 32'(bus.regWrite), 32'd0);
        chk("s1_empty",  32'(bus.empty),    32'd1);
        chk_log("s1_log", 5'd8, 1);

        // Fill under hold, attempt an overfill, then release.
        bus.wb_hold = 1'b1;
        for (int i = 0; i < 4; i++) enq(5'(9 + i), 32'h100 + 32'(i));
        chk("s2_ready", 32'(bus.in_ready), 32'd0);
        chk("s2_we",    32'(bus.regWrite), 32'd0);
        enq(5'd13, 32'hDEAD);
        wlog.delete();
        bus.wb_hold = 1'b0;
        repeat (4) step();
        chk("s2_empty", 32'(bus.empty), 32'd1);
        chk_log("s2_log", 5'd9, 4);
        if (wlog.size() == 4) chk("s2_data3", wlog[3].val, 32'h103);

        // Forwarding: youngest match wins; address 0 never hits; in-flight request invisible.
        bus.wb_hold = 1'b1;
        enq(5'd17, 32'h40);
        enq(5'd17, 32'h41);
        enq(5'd5,  32'h55);
        bus.fwd1addr = 5'd17;
        bus.fwd2addr = 5'd0;
        #1;
        chk("s3_hit1",  32'(bus.fwd1hit),  FWD ? 32'd1 : 32'd0);
        chk("s3_data1", bus.fwd1data,      FWD ? 32'h41 : 32'h0);
        chk("s3_hit2",  32'(bus.fwd2hit),  32'd0);
        chk("s3_data2", bus.fwd2data,      32'h0);
        bus.fwd2addr = 5'd5;
        bus.fwd1addr = 5'd22;
        bus.in_valid = 1'b1;
        bus.in_addr  = 5'd22;
        bus.in_data  = 32'h2222;
        #1;
        chk("s3_hit2b",  32'(bus.fwd2hit), FWD ? 32'd1 : 32'd0);
        chk("s3_data2b", bus.fwd2data,     FWD ? 32'h55 : 32'h0);
        chk("s3_nolive", 32'(bus.fwd1hit), 32'd0);
        step();
        bus.in_valid = 1'b0;
        chk("s3_hit1c", 32'(bus.fwd1hit), FWD ? 32'd1 : 32'd0);
        drain();
        bus.fwd1addr = '0;
        bus.fwd2addr = '0;

        // Register 0 completes the handshake but is dropped.
        bus.in_valid = 1'b1;
        bus.in_addr  = 5'd0;
        bus.in_data  = 32'hFFFF_FFFF;
        #1;
        chk("s4_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk("s4_empty", 32'(bus.empty),    32'd1);
        chk("s4_we",    32'(bus.regWrite), 32'd0);
        step();
        chk("s4_we2",   32'(bus.regWrite), 32'd0);

        // Asynchronous reset mid-cycle with three entries queued.
        bus.wb_hold = 1'b1;
        for (int i = 0; i < 3; i++) enq(5'(20 + i), 32'h200 + 32'(i));
        bus.wb_hold = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("s5_we",    32'(bus.regWrite), 32'd0);
        chk("s5_empty", 32'(bus.empty),    32'd1);
        chk("s5_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;
        step();
        enq(5'd3, 32'h33);
        chk("s5_we2",   32'(bus.regWrite), 32'd1);
        chk("s5_addr2", 32'(bus.regWaddr), 32'd3);
        chk("s5_data2", bus.data,          32'h33);
        step();

        // Steady push+pop at count 2 across pointer wrap.
        wlog.delete();
        bus.wb_hold = 1'b1;
        enq(5'd1, 32'h1001);
        enq(5'd2, 32'h1002);
        bus.wb_hold = 1'b0;
        for (int i = 0; i < 6; i++) begin
            enq(5'(3 + i), 32'h1003 + 32'(i));
            chk("s6_nonempty", 32'(bus.empty),    32'd0);
            chk("s6_ready",    32'(bus.in_ready), 32'd1);
        end
        drain();
        chk_log("s6_log", 5'd1, 8);
        if (wlog.size() == 8) chk("s6_data7", wlog[7].val, 32'h1008);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
